spart_gen2: RTL and testbench

SPART_GEN2 -- requirements
Module: spart_gen2

---
 rtl/spart_gen2.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_spart_gen2.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_gen2.sv
// spart_gen2: UART with a register bus and TX/RX byte queues.
// Define SPART_PARITY_EN to build the optional parity generate/check.
module spart_gen2 #(
  parameter int QUEUE_DEPTH  = 8,
  parameter int CLK_HZ       = 50000000,
  parameter int DEFAULT_BAUD = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs_n,
  input  logic       iorw_n,
  input  logic [2:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       tx_q_full,
  output logic       rx_q_empty,
  output logic       TX,
  input  logic       RX
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [12:0] DIV_RST =
    13'((CLK_HZ + DEFAULT_BAUD / 2) / DEFAULT_BAUD);
  localparam logic [2:0] A_DBUF = 3'd0;
  localparam logic [2:0] A_SREG = 3'd1;
  localparam logic [2:0] A_DBL  = 3'd2;
  localparam logic [2:0] A_DBH  = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic       wr, rd, wr_ctrl;
  logic [7:0] wdata, rdata, sreg, ctrl_rd;
  logic [12:0] div;
  logic [4:0]  div_hi;
  logic        stop2, ovr;
`ifdef SPART_PARITY_EN
  logic [1:0]  par;
  logic        perr, perr_set;
`endif

  assign wr      = !iocs_n && !iorw_n;
  assign rd      = !iocs_n && iorw_n;
  assign wr_ctrl = wr && ioaddr == A_CTRL;
  assign wdata   = databus;
  assign databus = rd ? rdata : 8'bz;

  // Queues: extra pointer bit separates full from empty
  logic [7:0]  tx_mem [QUEUE_DEPTH];
  logic [7:0]  rx_mem [QUEUE_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_diff, rx_diff;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, rx_push, rx_pop, rx_ovf;
  logic [4:0]  tx_used, rx_used, tx_free;
  logic [7:0]  tx_head, rx_head;

  state_t      tx_st, rx_st;
  logic [12:0] tx_cnt, tx_div, rx_cnt, rx_div;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_sh, rx_sh;
  logic        tx_line, tx_two, tx_end;
  logic        rx_s1, rx_s2, rx_prev, rx_tick;
`ifdef SPART_PARITY_EN
  logic        tx_pen, tx_pbit, rx_pen, rx_podd;
`endif

  assign tx_empty = tx_wp == tx_rp;
  assign rx_empty = rx_wp == rx_rp;
  assign tx_full  = tx_wp[AW] != tx_rp[AW] &&
                    tx_wp[AW-1:0] == tx_rp[AW-1:0];
  assign rx_full  = rx_wp[AW] != rx_rp[AW] &&
                    rx_wp[AW-1:0] == rx_rp[AW-1:0];
  assign tx_diff  = tx_wp - tx_rp;
  assign rx_diff  = rx_wp - rx_rp;
  assign tx_used  = 5'(tx_diff);
  assign rx_used  = 5'(rx_diff);
  assign tx_free  = 5'(QUEUE_DEPTH) - tx_used;
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  assign tx_push = wr && ioaddr == A_DBUF && !tx_full;
  assign tx_pop  = tx_st == IDLE && !tx_empty;
  assign rx_pop  = rd && ioaddr == A_DBUF && !rx_empty;
  assign rx_tick = (rx_st == START) ? (rx_cnt == {1'b0, rx_div[12:1]})
                                    : (rx_cnt == rx_div - 13'd1);
  assign rx_push = rx_st == STOP && rx_tick && !rx_full;
  assign rx_ovf  = rx_st == STOP && rx_tick && rx_full;
  assign tx_end  = tx_cnt == tx_div - 13'd1;
`ifdef SPART_PARITY_EN
  assign perr_set = rx_st == PARITY && rx_tick &&
                    (rx_s2 != (^rx_sh ^ rx_podd));
  assign ctrl_rd  = {3'b0, perr, ovr, stop2, par};
`else
  assign ctrl_rd  = {4'b0, ovr, stop2, 2'b00};
`endif

  assign sreg = {tx_free[4] ? 4'hF : tx_free[3:0],
                 rx_used[4] ? 4'hF : rx_used[3:0]};

  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      A_DBUF:  rdata = rx_empty ? 8'h00 : rx_head;
      A_SREG:  rdata = sreg;
      A_DBL:   rdata = div[7:0];
      A_DBH:   rdata = {3'b0, div[12:8]};
      A_CTRL:  rdata = ctrl_rd;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= DIV_RST;
      div_hi <= DIV_RST[12:8];
    end else if (wr) begin
      if (ioaddr == A_DBH) div_hi <= wdata[4:0];
      if (ioaddr == A_DBL) div <= {div_hi, wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop2 <= 1'b0;
      ovr   <= 1'b0;
`ifdef SPART_PARITY_EN
      par   <= 2'b00;
      perr  <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        stop2 <= wdata[2];
`ifdef SPART_PARITY_EN
        par   <= wdata[1:0];
`endif
      end
      ovr <= rx_ovf | (ovr & ~(wr_ctrl & wdata[3]));
`ifdef SPART_PARITY_EN
      perr <= perr_set | (perr & ~(wr_ctrl & wdata[4]));
`endif
    end
  end

  // Divisor, stop count and parity mode are latched per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st   <= IDLE;
      tx_line <= 1'b1;
      tx_cnt  <= '0;
      tx_div  <= DIV_RST;
      tx_bit  <= '0;
      tx_sh   <= '0;
      tx_two  <= 1'b0;
`ifdef SPART_PARITY_EN
      tx_pen  <= 1'b0;
      tx_pbit <= 1'b0;
`endif
    end else begin
      if (tx_st != IDLE) tx_cnt <= tx_end ? '0 : tx_cnt + 13'd1;
      unique case (tx_st)
        IDLE: if (!tx_empty) begin
          tx_st   <= START;
          tx_line <= 1'b0;
          tx_sh   <= tx_head;
          tx_div  <= div;
          tx_cnt  <= '0;
          tx_bit  <= '0;
          tx_two  <= stop2;
`ifdef SPART_PARITY_EN
          tx_pen  <= par == 2'b01 || par == 2'b10;
          tx_pbit <= ^tx_head ^ (par == 2'b10);
`endif
        end
        START: if (tx_end) begin
          tx_st   <= DATA;
          tx_line <= tx_sh[0];
        end
        DATA: if (tx_end) begin
          if (tx_bit == 3'd7) begin
            tx_bit <= '0;
`ifdef SPART_PARITY_EN
            if (tx_pen) begin
              tx_st   <= PARITY;
              tx_line <= tx_pbit;
            end else
`endif
            begin
              tx_st   <= STOP;
              tx_line <= 1'b1;
            end
          end else begin
            tx_bit  <= tx_bit + 3'd1;
            tx_sh   <= tx_sh >> 1;
            tx_line <= tx_sh[1];
          end
        end
`ifdef SPART_PARITY_EN
        PARITY: if (tx_end) begin
          tx_st   <= STOP;
          tx_line <= 1'b1;
        end
`endif
        STOP: if (tx_end) begin
          if (tx_two && tx_bit == 3'd0) tx_bit <= 3'd1;
          else tx_st <= IDLE;
        end
        default: tx_st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_cnt  <= '0;
      rx_div  <= DIV_RST;
      rx_bit  <= '0;
      rx_sh   <= '0;
`ifdef SPART_PARITY_EN
      rx_pen  <= 1'b0;
      rx_podd <= 1'b0;
`endif
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_st != IDLE) rx_cnt <= rx_tick ? '0 : rx_cnt + 13'd1;
      unique case (rx_st)
        IDLE: if (rx_prev && !rx_s2) begin
          rx_st   <= START;
          rx_cnt  <= '0;
          rx_div  <= div;
          rx_bit  <= '0;
`ifdef SPART_PARITY_EN
          rx_pen  <= par == 2'b01 || par == 2'b10;
          rx_podd <= par == 2'b10;
`endif
        end
        START: if (rx_tick) rx_st <= rx_s2 ? IDLE : DATA;
        DATA: if (rx_tick) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7)
`ifdef SPART_PARITY_EN
            rx_st <= rx_pen ? PARITY : STOP;
`else
            rx_st <= STOP;
`endif
        end
`ifdef SPART_PARITY_EN
        PARITY: if (rx_tick) rx_st <= STOP;
`endif
        STOP: if (rx_tick) rx_st <= IDLE;
        default: rx_st <= IDLE;
      endcase
    end
  end

  assign TX         = tx_line;
  assign tx_q_full  = tx_full;
  assign rx_q_empty = rx_empty;
endmodule

// File: tb/tb_spart_gen2.sv
// Directed testbench for spart_gen2: registers, queues, framing, reset.
// Parity scenario is compiled only when SPART_PARITY_EN is defined.
module tb_spart_gen2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs_n = 1'b1;
  logic       iorw_n = 1'b1;
  logic [2:0] ioaddr = 3'd0;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] databus;
  logic       tx_q_full, rx_q_empty, TX;
  logic       RX = 1'b1;
  int checks = 0;
  int errors = 0;

  assign databus = drv_en ? drv : 8'bz;

  spart_gen2 dut (
    .clk(clk), .rst_n(rst_n), .iocs_n(iocs_n), .iorw_n(iorw_n),
    .ioaddr(ioaddr), .databus(databus), .tx_q_full(tx_q_full),
    .rx_q_empty(rx_q_empty), .TX(TX), .RX(RX)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs_n = 1'b0; iorw_n = 1'b0; ioaddr = a; drv = d; drv_en = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    drv_en = 1'b0; iocs_n = 1'b0; iorw_n = 1'b1; ioaddr = a;
    #2 d = databus;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    iocs_n = 1'b1; iorw_n = 1'b1; drv_en = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bench-side UART driver, 16 clocks per bit
  task automatic send_rx(input logic [7:0] b, input bit pe, input logic pb);
    RX = 1'b0; wait_cyc(16);
    for (int i = 0; i < 8; i++) begin RX = b[i]; wait_cyc(16); end
    if (pe) begin RX = pb; wait_cyc(16); end
    RX = 1'b1; wait_cyc(20);
  endtask

  // Bench-side UART decoder of TX, 16 clocks per bit
  task automatic get_tx(input bit pe, output logic [7:0] b,
                        output logic pb, output bit ok);
    ok = 1'b0; b = 8'h00; pb = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (TX === 1'b0);
    end
    if (ok) begin
      wait_cyc(8);
      for (int i = 0; i < 8; i++) begin wait_cyc(16); b[i] = TX; end
      if (pe) begin wait_cyc(16); pb = TX; end
      wait_cyc(16);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n = 1'b0; wait_cyc(3);
    checks++;
    if (TX !== 1'b1 || tx_q_full !== 1'b0 || rx_q_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_pins got TX=%b full=%b empty=%b want 1 0 1",
               TX, tx_q_full, rx_q_empty);
    end
    rst_n = 1'b1; wait_cyc(2);
    bus_rd(3'd1, d); checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL reset_sreg got %h want 80", d); end
    bus_rd(3'd3, d); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL reset_dbh got %h want 01", d); end
    bus_rd(3'd2, d); checks++;
    if (d !== 8'hB2) begin errors++; $display("FAIL reset_dbl got %h want b2", d); end
    bus_rd(3'd4, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", d); end
    bus_rd(3'd6, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reserved_rd got %h want 00", d); end
    bus_idle();
  endtask

  task automatic test_ctrl();
    logic [7:0] d, exp;
`ifdef SPART_PARITY_EN
    exp = 8'h07;
`else
    exp = 8'h04;
`endif
    bus_wr(3'd4, 8'hF7);
    bus_wr(3'd7, 8'hFF);
    bus_rd(3'd4, d); checks++;
    if (d !== exp) begin errors++; $display("FAIL ctrl_wr got %h want %h", d, exp); end
    bus_wr(3'd4, 8'h00);
    bus_rd(3'd4, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ctrl_clr got %h want 00", d); end
    bus_rd(3'd2, d); checks++;
    if (d !== 8'hB2) begin errors++; $display("FAIL reserved_wr got %h want b2", d); end
    bus_idle();
  endtask

  task automatic test_divisor();
    logic [7:0] d;
    int lo;
    bit seen;
    bus_wr(3'd3, 8'h0A);
    bus_rd(3'd2, d); checks++;
    if (d !== 8'hB2) begin errors++; $display("FAIL dbh_staged got %h want b2", d); end
    bus_wr(3'd2, 8'h2C);
    bus_rd(3'd2, d); checks++;
    if (d !== 8'h2C) begin errors++; $display("FAIL dbl_commit got %h want 2c", d); end
    bus_rd(3'd3, d); checks++;
    if (d !== 8'h0A) begin errors++; $display("FAIL dbh_commit got %h want 0a", d); end
    bus_wr(3'd0, 8'h55);
    bus_idle();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (TX === 1'b0);
    end
    lo = 0;
    if (seen) begin
      lo = 1;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (TX !== 1'b0) break;
        lo++;
      end
    end
    checks++;
    if (lo != 2604) begin errors++; $display("FAIL start_bit_len got %0d want 2604", lo); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    wait_cyc(2604 + 100);
    checks++;
    if (TX !== 1'b0) begin errors++; $display("FAIL mid_frame_bit1 got %b want 0", TX); end
    rst_n = 1'b0;
    #1; checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx got %b want 1", TX); end
    wait_cyc(3);
    rst_n = 1'b1;
    bus_rd(3'd1, d); checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL rst_sreg got %h want 80", d); end
    bus_rd(3'd2, d); checks++;
    if (d !== 8'hB2) begin errors++; $display("FAIL rst_dbl got %h want b2", d); end
    bus_idle();
    bus_wr(3'd3, 8'h00);
    bus_wr(3'd2, 8'h10);
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [9];
    logic [7:0] got [9];
    logic [7:0] d;
    logic pb;
    bit ok [9];
    int lows;
    exp = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 8'h80, 8'h7E, 8'h5A, 8'hC3, 8'h96};
    fork
      begin
        for (int i = 0; i < 9; i++) bus_wr(3'd0, exp[i]);
        bus_wr(3'd0, 8'hEE);
        #1; checks++;
        if (tx_q_full !== 1'b1) begin errors++; $display("FAIL tx_full got %b want 1", tx_q_full); end
        bus_rd(3'd1, d); checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL tx_sreg_full got %h want 00", d); end
        bus_idle();
      end
      begin
        for (int i = 0; i < 9; i++) get_tx(1'b0, got[i], pb, ok[i]);
      end
    join
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (!ok[i] || got[i] !== exp[i]) begin
        errors++;
        $display("FAIL tx_byte%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL tx_dropped got %0d low cycles want 0", lows); end
    bus_rd(3'd1, d); checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL tx_drained got %h want 80", d); end
    bus_idle();
  endtask

  task automatic test_rx_overrun();
    logic [7:0] b [9];
    logic [7:0] d;
    b = '{8'h31, 8'hC4, 8'h7F, 8'h00, 8'hE8, 8'h5B, 8'h92, 8'hAA, 8'h0F};
    for (int i = 0; i < 9; i++) send_rx(b[i], 1'b0, 1'b0);
    bus_rd(3'd1, d); checks++;
    if (d !== 8'h88) begin errors++; $display("FAIL rx_sreg got %h want 88", d); end
    bus_rd(3'd4, d); checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL rx_ovr got %h want 08", d); end
    for (int i = 0; i < 8; i++) begin
      bus_rd(3'd0, d); checks++;
      if (d !== b[i]) begin errors++; $display("FAIL rx_byte%0d got %h want %h", i, d, b[i]); end
    end
    bus_rd(3'd0, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rx_empty_rd got %h want 00", d); end
    bus_wr(3'd4, 8'h08);
    bus_rd(3'd4, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovr_w1c got %h want 00", d); end
    bus_idle();
    checks++;
    if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL rx_q_empty got %b want 1", rx_q_empty); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    RX = 1'b0; wait_cyc(5);
    RX = 1'b1; wait_cyc(200);
    bus_rd(3'd1, d); checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL glitch_sreg got %h want 80", d); end
    bus_idle();
    checks++;
    if (rx_q_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty got %b want 1", rx_q_empty); end
  endtask

`ifdef SPART_PARITY_EN
  task automatic test_parity();
    logic [7:0] d, b;
    logic pb;
    bit ok;
    bus_wr(3'd4, 8'h01);
    bus_wr(3'd0, 8'h07);
    bus_idle();
    get_tx(1'b1, b, pb, ok);
    checks++;
    if (!ok || b !== 8'h07 || pb !== 1'b1) begin
      errors++;
      $display("FAIL tx_parity got %h/%b want 07/1", b, pb);
    end
    wait_cyc(40);
    send_rx(8'h07, 1'b1, 1'b0);
    bus_rd(3'd4, d); checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL perr_set got %h want 11", d); end
    bus_rd(3'd0, d); checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL perr_byte got %h want 07", d); end
    bus_wr(3'd4, 8'h10);
    bus_rd(3'd4, d); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL perr_w1c got %h want 00", d); end
    bus_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_ctrl();
    test_divisor();
    test_reset_mid_frame();
    test_back_to_back();
    test_rx_overrun();
    test_glitch();
`ifdef SPART_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
